// File: rtl/updown_counter_mod_if.sv
// Control and status bundle for updown_counter_mod.
// The master drives the count controls; the slave (the counter) returns count and status.
interface updown_counter_mod_if #(
  parameter int N = 8
);
  logic         en;
  logic         count_dir;
  logic         load;
  logic [N-1:0] load_val;
  logic         flag_clr;
  logic [N-1:0] count_out;
  logic         tc;
  logic         wrap;
  logic         ovf;
  logic         unf;

  modport master (
    output en, count_dir, load, load_val, flag_clr,
    input  count_out, tc, wrap, ovf, unf
  );

  modport slave (
    input  en, count_dir, load, load_val, flag_clr,
    output count_out, tc, wrap, ovf, unf
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, wrap or saturate at the range ends,
// parallel load with clamping, and sticky overflow/underflow flags.
module updown_counter_mod #(
  parameter int     N        = 8,
  parameter longint MODULUS  = 256,
  parameter bit     SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_counter_mod_if.slave  bus
);

  generate
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< N)) begin : g_bad_modulus
      $error("updown_counter_mod: MODULUS must lie in 2..2**N");
    end
  endgenerate

  // One extra bit so MODULUS = 2**N neither truncates nor aliases to zero.
  localparam logic [N:0]   MAX_EXT = (N+1)'(MODULUS - 1);
  localparam logic [N-1:0] TOP     = MAX_EXT[N-1:0];

  logic [N-1:0] count_reg, count_next;
  logic         wrap_reg, wrap_next;
  logic         ovf_reg, ovf_next;
  logic         unf_reg, unf_next;

  logic [N:0]   count_ext;
  logic [N:0]   load_ext;
  logic [N:0]   count_plus;
  logic [N-1:0] count_minus;
  logic         at_top;
  logic         at_bottom;

  assign count_ext   = {1'b0, count_reg};
  assign load_ext    = {1'b0, bus.load_val};
  assign count_plus  = count_ext + {{N{1'b0}}, 1'b1};
  assign count_minus = count_reg - {{(N-1){1'b0}}, 1'b1};
  assign at_top      = (count_ext == MAX_EXT);
  assign at_bottom   = (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    // Clear first so a same-edge overflow/underflow below overrides it.
    ovf_next   = ovf_reg & ~bus.flag_clr;
    unf_next   = unf_reg & ~bus.flag_clr;
    if (bus.load) begin
      count_next = (load_ext > MAX_EXT) ? TOP : bus.load_val;
    end else if (bus.en) begin
      if (bus.count_dir) begin
        if (at_top) begin
          ovf_next = 1'b1;
          if (!SATURATE) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_plus[N-1:0];
        end
      end else begin
        if (at_bottom) begin
          unf_next = 1'b1;
          if (!SATURATE) begin
            count_next = TOP;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_minus;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign bus.count_out = count_reg;
  assign bus.wrap      = wrap_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.unf       = unf_reg;
  assign bus.tc        = bus.count_dir ? at_top : at_bottom;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: three configurations share one stimulus stream,
// an arithmetic model is compared every cycle, and literal values pin key points.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       count_dir = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       flag_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter_mod_if #(.N(8)) bus_a ();
  updown_counter_mod_if #(.N(8)) bus_b ();
  updown_counter_mod_if #(.N(4)) bus_c ();

  assign bus_a.en = en;  assign bus_a.count_dir = count_dir;  assign bus_a.load = load;
  assign bus_a.load_val = load_val;  assign bus_a.flag_clr = flag_clr;
  assign bus_b.en = en;  assign bus_b.count_dir = count_dir;  assign bus_b.load = load;
  assign bus_b.load_val = load_val;  assign bus_b.flag_clr = flag_clr;
  assign bus_c.en = en;  assign bus_c.count_dir = count_dir;  assign bus_c.load = load;
  assign bus_c.load_val = load_val[3:0];  assign bus_c.flag_clr = flag_clr;

  updown_counter_mod #(.N(8), .MODULUS(10), .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  updown_counter_mod #(.N(8), .MODULUS(10), .SATURATE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  updown_counter_mod #(.N(4), .MODULUS(16), .SATURATE(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // DUT outputs gathered per configuration: 0 = A (mod 10 wrap), 1 = B (mod 10 sat), 2 = C (mod 16 wrap)
  int   dut_cnt[3];
  logic dut_tc[3], dut_wrap[3], dut_ovf[3], dut_unf[3];
  assign dut_cnt[0] = int'(bus_a.count_out);
  assign dut_cnt[1] = int'(bus_b.count_out);
  assign dut_cnt[2] = int'(bus_c.count_out);
  assign dut_tc[0] = bus_a.tc;     assign dut_tc[1] = bus_b.tc;     assign dut_tc[2] = bus_c.tc;
  assign dut_wrap[0] = bus_a.wrap; assign dut_wrap[1] = bus_b.wrap; assign dut_wrap[2] = bus_c.wrap;
  assign dut_ovf[0] = bus_a.ovf;   assign dut_ovf[1] = bus_b.ovf;   assign dut_ovf[2] = bus_c.ovf;
  assign dut_unf[0] = bus_a.unf;   assign dut_unf[1] = bus_b.unf;   assign dut_unf[2] = bus_c.unf;

  localparam int MOD_V[3]  = '{10, 10, 16};
  localparam bit SAT_V[3]  = '{1'b0, 1'b1, 1'b0};
  localparam int MASK_V[3] = '{255, 255, 15};

  int mc[3];
  bit mw[3], mo[3], mu[3];
  bit model_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_load(input int k, input int lv);
    int v;
    v = lv & MASK_V[k];
    return (v < MOD_V[k]) ? v : MOD_V[k] - 1;
  endfunction

  // Model: count lives in 0..M-1; stepping past either end is an overflow/underflow event.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mc[k] <= 0; mw[k] <= 1'b0; mo[k] <= 1'b0; mu[k] <= 1'b0;
      end else begin
        mw[k] <= 1'b0;
        if (flag_clr) begin
          mo[k] <= 1'b0;
          mu[k] <= 1'b0;
        end
        if (load) begin
          mc[k] <= clamp_load(k, int'(load_val));
        end else if (en && count_dir) begin
          if (mc[k] + 1 < MOD_V[k]) mc[k] <= mc[k] + 1;
          else begin
            mo[k] <= 1'b1;
            if (!SAT_V[k]) begin mc[k] <= (mc[k] + 1) % MOD_V[k]; mw[k] <= 1'b1; end
          end
        end else if (en) begin
          if (mc[k] > 0) mc[k] <= mc[k] - 1;
          else begin
            mu[k] <= 1'b1;
            if (!SAT_V[k]) begin mc[k] <= MOD_V[k] - 1; mw[k] <= 1'b1; end
          end
        end
      end
    end
    if (rst) model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_cnt[%0d]", k), dut_cnt[k], mc[k]);
        chk($sformatf("model_wrap[%0d]", k), int'(dut_wrap[k]), int'(mw[k]));
        chk($sformatf("model_ovf[%0d]", k), int'(dut_ovf[k]), int'(mo[k]));
        chk($sformatf("model_unf[%0d]", k), int'(dut_unf[k]), int'(mu[k]));
        chk($sformatf("model_tc[%0d]", k), int'(dut_tc[k]),
            int'(count_dir ? (mc[k] == MOD_V[k] - 1) : (mc[k] == 0)));
      end
    end
  end

  // Drive one cycle's inputs, let the edge happen, and return just after it.
  task automatic step(input bit r, input bit l, input bit e, input bit d, input bit c, input int lv);
    rst = r; load = l; en = e; count_dir = d; flag_clr = c; load_val = 8'(lv);
    @(posedge clk);
    #1;
    $display("step rst=%0b load=%0b en=%0b dir=%0b clr=%0b lv=%0d -> A=%0d B=%0d C=%0d",
             r, l, e, d, c, lv, dut_cnt[0], dut_cnt[1], dut_cnt[2]);
  endtask

  int up_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_cnt[4]  = '{1, 0, 0, 0};
  int dn_unf[4]  = '{0, 0, 1, 1};

  // rst, load, en, dir, clr, load_val
  int vec[10][6] = '{
    '{0, 1, 0, 0, 0, 8},  '{0, 0, 1, 1, 0, 0},  '{0, 0, 1, 0, 0, 0},  '{0, 0, 1, 1, 0, 0},
    '{0, 0, 1, 1, 1, 0},  '{0, 1, 1, 0, 0, 0},  '{0, 0, 1, 0, 0, 0},  '{0, 0, 0, 1, 1, 0},
    '{0, 1, 0, 1, 0, 15}, '{0, 0, 1, 1, 0, 0}
  };

  initial begin
    // Reset with en high
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    chk("reset_cnt", dut_cnt[0], 0);
    chk("reset_wrap", int'(dut_wrap[0]), 0);
    chk("reset_ovf", int'(dut_ovf[0]), 0);
    chk("reset_unf", int'(dut_unf[0]), 0);

    // Up wrap on A
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 1, 0, 0);
      chk($sformatf("up_cnt[%0d]", i), dut_cnt[0], up_exp[i]);
      chk($sformatf("up_wrap[%0d]", i), int'(dut_wrap[0]), (i == 9) ? 1 : 0);
      chk($sformatf("up_tc[%0d]", i), int'(dut_tc[0]), (i == 8) ? 1 : 0);
      chk($sformatf("up_ovf[%0d]", i), int'(dut_ovf[0]), (i >= 9) ? 1 : 0);
    end

    // Load clamp beats en; ovf untouched
    step(0, 1, 1, 1, 0, 200);
    chk("clamp_cnt_a", dut_cnt[0], 9);
    chk("clamp_wrap_a", int'(dut_wrap[0]), 0);
    chk("clamp_ovf_a", int'(dut_ovf[0]), 1);
    chk("clamp_cnt_c", dut_cnt[2], 8);

    // Overflow on the same edge as flag_clr: set wins
    step(0, 0, 1, 1, 1, 0);
    chk("clrset_cnt", dut_cnt[0], 0);
    chk("clrset_ovf", int'(dut_ovf[0]), 1);
    chk("clrset_wrap", int'(dut_wrap[0]), 1);
    step(0, 0, 0, 1, 1, 0);
    chk("clr_ovf", int'(dut_ovf[0]), 0);
    chk("clr_wrap", int'(dut_wrap[0]), 0);

    // Down saturate on B
    step(0, 1, 0, 0, 0, 2);
    chk("sat_load", dut_cnt[1], 2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0);
      chk($sformatf("sat_cnt[%0d]", i), dut_cnt[1], dn_cnt[i]);
      chk($sformatf("sat_unf[%0d]", i), int'(dut_unf[1]), dn_unf[i]);
      chk($sformatf("sat_wrap[%0d]", i), int'(dut_wrap[1]), 0);
    end

    // Full 4-bit range on C
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("full_cnt", dut_cnt[2], 15);
    chk("full_unf", int'(dut_unf[2]), 1);
    chk("full_wrap", int'(dut_wrap[2]), 1);
    chk("mod10_down_cnt", dut_cnt[0], 9);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk($sformatf("full_hold[%0d]", i), dut_cnt[2], 15);
      chk($sformatf("full_hold_wrap[%0d]", i), int'(dut_wrap[2]), 0);
    end
    chk("full_tc_down", int'(dut_tc[2]), 0);
    count_dir = 1'b1;
    #1;
    chk("full_tc_up", int'(dut_tc[2]), 1);

    // Mixed directed vectors, checked by the model
    for (int i = 0; i < 10; i++)
      step(vec[i][0] != 0, vec[i][1] != 0, vec[i][2] != 0, vec[i][3] != 0, vec[i][4] != 0, vec[i][5]);

    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
